subsys_feeder: RTL

Upstream operand feeder for the systolic-array subsystem input FIFO.
- Accepts a frame of DIN_WIDTH-wide beats from a host stream (valid/ready).
- Packs every 2*N beats into one BUS_WIDTH word and writes it into the subsystem input FIFO via wr_fifo, honouring in_fifo_full.
- Counts M_minus_one+1 words per frame, then signals done.

---
 rtl/subsys_pkg.sv | 18 +
 rtl/subsys_feeder_if.sv | 25 ++
 rtl/subsys_feeder.sv | 119 +++++++++++
 3 files changed

// File: rtl/subsys_pkg.sv
// Shared types and sizing helpers for the subsystem operand feeder.
package subsys_pkg;

   typedef enum logic [1:0] {IDLE, PACK, PUSH, DONE} feeder_state_e;

   localparam int DIN_WIDTH_DEF = 8;
   localparam int N_DEF         = 4;

   // One packed word carries two rows of N elements.
   function automatic int beats_per_word(input int n);
      return 2 * n;
   endfunction

   function automatic int beat_cnt_width(input int n);
      return (2 * n > 1) ? $clog2(2 * n) : 1;
   endfunction

endpackage

// File: rtl/subsys_feeder_if.sv
// Host beat stream plus subsystem input-FIFO write port of the feeder.
// master = feeder side, slave = host/FIFO side.
interface subsys_feeder_if
   import subsys_pkg::*;
#(
   parameter int DIN_WIDTH = DIN_WIDTH_DEF,
   parameter int BUS_WIDTH = 2 * DIN_WIDTH_DEF * N_DEF
);
   logic [DIN_WIDTH-1:0] s_data;
   logic                 s_valid;
   logic                 s_ready;
   logic [BUS_WIDTH-1:0] fifo_din;
   logic                 wr_fifo;
   logic                 in_fifo_full;

   modport master (
      input  s_data, s_valid, in_fifo_full,
      output s_ready, fifo_din, wr_fifo
   );

   modport slave (
      output s_data, s_valid, in_fifo_full,
      input  s_ready, fifo_din, wr_fifo
   );
endinterface

// File: rtl/subsys_feeder.sv
// Packs 2*N host beats per word and writes M_minus_one+1 words per frame into
// the subsystem input FIFO. Optional abort input: define SUBSYS_FEEDER_ABORT_EN.
module subsys_feeder
   import subsys_pkg::*;
#(
   parameter int DIN_WIDTH = DIN_WIDTH_DEF,
   parameter int N         = N_DEF,
   parameter int BUS_WIDTH = 2 * DIN_WIDTH * N
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic [7:0]            M_minus_one,
   input  logic                  start,
`ifdef SUBSYS_FEEDER_ABORT_EN
   input  logic                  abort,
`endif
   subsys_feeder_if.master       bus,
   output logic                  busy,
   output logic                  done
);

   localparam int BEATS = beats_per_word(N);
   localparam int BCW   = beat_cnt_width(N);

   feeder_state_e        state_q, state_d;
   logic [BCW-1:0]       beat_cnt_q;
   logic [7:0]           word_cnt_q;
   logic [7:0]           m_lat_q;
   logic [BUS_WIDTH-1:0] pack_q;
   logic [BUS_WIDTH-1:0] fifo_din_q;
   logic [BUS_WIDTH-1:0] next_word;
   logic                 accept;
   logic                 last_beat;
   logic                 kill;

   assign bus.fifo_din = fifo_din_q;

   // NOTE: every signal driven here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      bus.s_ready = 1'b0;
      bus.wr_fifo = 1'b0;
      done        = 1'b0;
      busy        = (state_q != IDLE);
`ifdef SUBSYS_FEEDER_ABORT_EN
      kill        = abort && (state_q != IDLE);
`else
      kill        = 1'b0;
`endif
      accept      = (state_q == PACK) && bus.s_valid && !kill;
      last_beat   = (beat_cnt_q == BCW'(BEATS - 1));
      next_word   = pack_q;
      next_word[int'(beat_cnt_q) * DIN_WIDTH +: DIN_WIDTH] = bus.s_data;

      unique case (state_q)
         IDLE: if (start) state_d = PACK;
         PACK: begin
            bus.s_ready = 1'b1;
            if (accept && last_beat) state_d = PUSH;
         end
         PUSH: begin
            bus.wr_fifo = !bus.in_fifo_full;
            if (bus.wr_fifo) state_d = (word_cnt_q == m_lat_q) ? DONE : PACK;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over everything, including a pending FIFO write, and
      // drops s_ready so the host never sees a beat silently discarded.
      if (kill) begin
         state_d     = IDLE;
         bus.wr_fifo = 1'b0;
         bus.s_ready = 1'b0;
      end
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         word_cnt_q <= '0;
         m_lat_q    <= '0;
         pack_q     <= '0;
         fifo_din_q <= '0;
      end else begin
         state_q <= state_d;
         if (kill) begin
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
            pack_q     <= '0;
         end else begin
            if (state_q == IDLE && start) begin
               m_lat_q    <= M_minus_one;
               word_cnt_q <= '0;
               beat_cnt_q <= '0;
            end
            if (accept) begin
               pack_q <= next_word;
               if (last_beat) begin
                  beat_cnt_q <= '0;
                  fifo_din_q <= next_word;
               end else begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
               end
            end
            // Compare before increment: m_lat=255 yields 256 words cleanly.
            if (bus.wr_fifo && word_cnt_q != m_lat_q) word_cnt_q <= word_cnt_q + 8'd1;
         end
      end
   end

endmodule
